// File: rtl/proc_pkg.sv
// Shared constants for the instruction processor controller: opcodes,
// bus mux select codes and tick (state) encodings.
package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'd0;
  localparam logic [2:0] OP_MVI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_DISP = 3'd4;

  localparam logic [3:0] SEL_G    = 4'd8;
  localparam logic [3:0] SEL_DIN  = 4'd9;
  localparam logic [3:0] SEL_NONE = 4'd15;

  // Tick vector doubles as the FSM state encoding.
  localparam logic [3:0] TICK_IDLE = 4'b0000;
  localparam logic [3:0] TICK_T0   = 4'b0001;
  localparam logic [3:0] TICK_T1   = 4'b0010;
  localparam logic [3:0] TICK_T2   = 4'b0100;
  localparam logic [3:0] TICK_T3   = 4'b1000;

endpackage

// File: rtl/proc_controller.sv
// Control FSM for the 8-register processor: fetches {op,X,Y} in T0 and
// sequences register/bus/ALU strobes over ticks T1..T3.
module proc_controller
  import proc_pkg::*;
#(
  parameter int DIN_W = 9,
  parameter int NREG  = 8,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIN_W-1:0] din,
  output logic             ir_en,
  output logic [NREG-1:0]  r_en,
  output logic             a_en,
  output logic             g_en,
  output logic             addsub,
  output logic [SEL_W-1:0] bus_sel,
  output logic             disp_en,
  output logic             done,
  output logic [3:0]       tick
);

  logic [3:0]       state_q, state_d;
  logic [DIN_W-1:0] ir_q, ir_d;
  logic [2:0]       op, x, y;

  function automatic logic [NREG-1:0] dec3(input logic [2:0] idx);
    dec3      = '0;
    dec3[idx] = 1'b1;
  endfunction

  assign op   = ir_q[8:6];
  assign x    = ir_q[5:3];
  assign y    = ir_q[2:0];
  assign tick = state_q;

  always_comb begin
    ir_en   = 1'b0;
    r_en    = '0;
    a_en    = 1'b0;
    g_en    = 1'b0;
    addsub  = 1'b0;
    bus_sel = SEL_W'(SEL_NONE);
    disp_en = 1'b0;
    done    = 1'b0;
    case (state_q)
      TICK_T0: ir_en = 1'b1;
      TICK_T1: begin
        case (op)
          OP_MV: begin
            bus_sel = SEL_W'(y);
            r_en    = dec3(x);
            done    = 1'b1;
          end
          OP_MVI: begin
            bus_sel = SEL_W'(SEL_DIN);
            r_en    = dec3(x);
            done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            bus_sel = SEL_W'(x);
            a_en    = 1'b1;
          end
          OP_DISP: begin
            bus_sel = SEL_W'(x);
            disp_en = 1'b1;
            done    = 1'b1;
          end
          default: done = 1'b1;
        endcase
      end
      TICK_T2: begin
        bus_sel = SEL_W'(y);
        g_en    = 1'b1;
        addsub  = (op == OP_SUB);
      end
      TICK_T3: begin
        bus_sel = SEL_W'(SEL_G);
        r_en    = dec3(x);
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  // run only matters in IDLE and in whichever tick finishes the instruction.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      TICK_IDLE: state_d = run ? TICK_T0 : TICK_IDLE;
      TICK_T0: begin
        ir_d    = din;
        state_d = TICK_T1;
      end
      TICK_T1: begin
        if (op == OP_ADD || op == OP_SUB) state_d = TICK_T2;
        else                              state_d = run ? TICK_T0 : TICK_IDLE;
      end
      TICK_T2: state_d = TICK_T3;
      TICK_T3: state_d = run ? TICK_T0 : TICK_IDLE;
      default: state_d = TICK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TICK_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_proc_controller.sv
// Bench for proc_controller: per-instruction output schedules in a queue,
// compared every cycle, plus directed literal checks.
module tb_proc_controller;

  typedef struct packed {
    logic [3:0] tick;
    logic       ir_en;
    logic [7:0] r_en;
    logic       a_en;
    logic       g_en;
    logic       addsub;
    logic [3:0] bus_sel;
    logic       disp_en;
    logic       done;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst, run;
  logic [8:0] din;
  logic       ir_en, a_en, g_en, addsub, disp_en, done;
  logic [7:0] r_en;
  logic [3:0] bus_sel, tick;
  obs_t       act;

  int n_chk = 0;
  int n_fail = 0;
  obs_t q[$];

  proc_controller dut (
    .clk(clk), .rst(rst), .run(run), .din(din),
    .ir_en(ir_en), .r_en(r_en), .a_en(a_en), .g_en(g_en), .addsub(addsub),
    .bus_sel(bus_sel), .disp_en(disp_en), .done(done), .tick(tick)
  );

  always #5 clk = ~clk;

  assign act = {tick, ir_en, r_en, a_en, g_en, addsub, bus_sel, disp_en, done};

  function automatic obs_t rec(input logic [3:0] t, input logic [3:0] bs);
    obs_t r;
    r = '0;
    r.tick = t;
    r.bus_sel = bs;
    return r;
  endfunction

  function automatic obs_t t0_rec();
    obs_t r;
    r = rec(4'b0001, 4'd15);
    r.ir_en = 1'b1;
    return r;
  endfunction

  function automatic obs_t exp_now();
    if (q.size() == 0) return rec(4'b0000, 4'd15);
    return q[0];
  endfunction

  // Whole remaining schedule of an instruction, derived from its opcode table.
  task automatic push_instr(input logic [8:0] d);
    logic [2:0] op, x, y;
    obs_t r;
    op = d[8:6]; x = d[5:3]; y = d[2:0];
    case (op)
      3'd0, 3'd1: begin
        r = rec(4'b0010, (op == 3'd0) ? {1'b0, y} : 4'd9);
        r.r_en = 8'b1 << x; r.done = 1'b1;
        q.push_back(r);
      end
      3'd2, 3'd3: begin
        r = rec(4'b0010, {1'b0, x}); r.a_en = 1'b1;
        q.push_back(r);
        r = rec(4'b0100, {1'b0, y}); r.g_en = 1'b1; r.addsub = (op == 3'd3);
        q.push_back(r);
        r = rec(4'b1000, 4'd8); r.r_en = 8'b1 << x; r.done = 1'b1;
        q.push_back(r);
      end
      3'd4: begin
        r = rec(4'b0010, {1'b0, x}); r.disp_en = 1'b1; r.done = 1'b1;
        q.push_back(r);
      end
      default: begin
        r = rec(4'b0010, 4'd15); r.done = 1'b1;
        q.push_back(r);
      end
    endcase
  endtask

  task automatic model_update();
    obs_t c;
    if (rst) q.delete();
    else if (q.size() == 0) begin
      if (run) q.push_back(t0_rec());
    end else begin
      c = q.pop_front();
      if (c.ir_en) push_instr(din);
      else if (c.done && run) q.push_back(t0_rec());
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic step(input logic r, input logic ru, input logic [8:0] d);
    rst = r; run = ru; din = d;
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("model", 32'(act), 32'(exp_now()));
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; din = '0;
    // 1. reset
    step(1, 1, 9'd0);
    step(1, 1, 9'd0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_bus", 32'(bus_sel), 32'hf);
    chk("rst_strobes", 32'({ir_en, r_en, a_en, g_en, addsub, disp_en, done}), 32'h0);
    // 2. mvi R3, 5
    step(0, 1, 9'd0);
    chk("mvi_t0", 32'({tick, ir_en}), 32'h3);
    step(0, 0, 9'b001_011_000);
    chk("mvi_t1", 32'({bus_sel, r_en, done}), {19'd0, 4'd9, 8'h08, 1'b1});
    step(0, 0, 9'd5);
    chk("mvi_idle", 32'(tick), 32'h0);
    // 3. add R1,R2
    step(0, 1, 9'd0);
    step(0, 0, 9'b010_001_010);
    chk("add_t1", 32'({a_en, bus_sel}), 32'h11);
    step(0, 0, 9'd0);
    chk("add_t2", 32'({g_en, addsub, bus_sel}), 32'h22);
    step(0, 0, 9'd0);
    chk("add_t3", 32'({bus_sel, r_en, done}), {19'd0, 4'd8, 8'h02, 1'b1});
    step(0, 0, 9'd0);
    // 4. sub R0,R7 then mv R4,R0 back to back
    step(0, 1, 9'd0);
    chk("b2b_tick0", 32'(tick), 32'h1);
    step(0, 1, 9'b011_000_111);
    chk("b2b_tick1", 32'(tick), 32'h2);
    step(0, 1, 9'd0);
    chk("b2b_tick2", 32'({tick, addsub}), 32'h9);
    step(0, 1, 9'd0);
    chk("b2b_tick3", 32'(tick), 32'h8);
    step(0, 1, 9'd0);
    chk("b2b_tick4", 32'(tick), 32'h1);
    step(0, 1, 9'b000_100_000);
    chk("b2b_mv", 32'({tick, bus_sel, r_en}), {16'd0, 4'b0010, 4'd0, 8'h10});
    step(0, 0, 9'd0);
    // 5. reset during T2 of add
    step(0, 1, 9'd0);
    step(0, 0, 9'b010_011_100);
    step(0, 0, 9'd0);
    step(1, 0, 9'd0);
    chk("rst_mid", 32'({tick, g_en, r_en}), 32'h0);
    step(0, 0, 9'd0);
    chk("rst_mid_nowrite", 32'({tick, r_en}), 32'h0);
    // 6. reserved opcode
    step(0, 1, 9'd0);
    step(0, 0, 9'b111_000_000);
    chk("rsv_t1", 32'({done, bus_sel, r_en, a_en, g_en, disp_en}), {20'd0, 1'b1, 4'hf, 8'h00, 3'b000});
    step(0, 0, 9'd0);
    chk("rsv_idle", 32'(tick), 32'h0);
    // randomized traffic against the schedule model
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6), 9'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
